// File: rtl/signed_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : signed_bcd_converter
//  Brief    : 16-bit two's-complement to sign + 5-digit BCD, double-dabble.
//  Revision : 1.0
// ============================================================================
module signed_bcd_converter #(
  parameter int HOLD_RESULT = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Load,
  output logic        Busy,
  output logic        Valid,
  output logic        Negative,
  output logic [19:0] Bcd,
  output logic [4:0]  Blank
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_count;
  logic [16:0] r_mag;
  logic [19:0] r_work;
  logic        r_neg;

  logic        w_accept;
  logic        w_last;
  logic [16:0] w_abs;
  logic [19:0] w_adj;
  logic [19:0] w_work_next;
  logic        w_shift_in;
  logic [4:0]  w_zero;
  logic [4:0]  w_blank;

  assign w_accept = Load && (r_state != CONVERT);
  assign w_last   = (r_state == CONVERT) && (r_count == 4'd15);
  assign w_abs    = Value[15] ? (17'd0 - {Value[15], Value}) : {1'b0, Value};

  // |Value| never exceeds 2^15, so bit 16 stays zero and bit 15 is the live MSB.
  assign w_shift_in  = r_mag[16] | r_mag[15];
  assign w_work_next = {w_adj[18:0], w_shift_in};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_digit
      assign w_adj[4*gi +: 4]  = (r_work[4*gi +: 4] >= 4'd5) ?
                                 (r_work[4*gi +: 4] + 4'd3) : r_work[4*gi +: 4];
      assign w_zero[gi]        = (w_work_next[4*gi +: 4] == 4'd0);
    end
  endgenerate

  assign w_blank = {w_zero[4],
                    &w_zero[4:3],
                    &w_zero[4:2],
                    &w_zero[4:1],
                    1'b0};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (Load)   w_state_next = CONVERT;
      CONVERT: if (w_last) w_state_next = DONE;
      DONE:    if (Load)   w_state_next = CONVERT;
      default:             w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count  <= 4'd0;
      r_mag    <= 17'd0;
      r_work   <= 20'd0;
      r_neg    <= 1'b0;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      Negative <= 1'b0;
      Bcd      <= 20'h00000;
      Blank    <= 5'b11110;
    end else if (w_accept) begin
      r_count <= 4'd0;
      r_mag   <= w_abs;
      r_work  <= 20'd0;
      r_neg   <= Value[15];
      Busy    <= 1'b1;
      Valid   <= 1'b0;
      if (HOLD_RESULT == 0) begin
        Negative <= 1'b0;
        Bcd      <= 20'h00000;
        Blank    <= 5'b11110;
      end
    end else if (r_state == CONVERT) begin
      r_count <= r_count + 4'd1;
      r_mag   <= {1'b0, r_mag[14:0], 1'b0};
      r_work  <= w_work_next;
      if (w_last) begin
        Bcd      <= w_work_next;
        Blank    <= w_blank;
        Negative <= r_neg;
        Valid    <= 1'b1;
        Busy     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_signed_bcd_converter
//  Brief    : Directed self-checking bench for signed_bcd_converter.
//  Revision : 1.0
// ============================================================================
module tb_signed_bcd_converter;

  logic        Clock;
  logic        Reset;
  logic [15:0] Value;
  logic        Load;
  logic        Busy, Valid, Negative;
  logic [19:0] Bcd;
  logic [4:0]  Blank;
  logic        Busy_c, Valid_c, Negative_c;
  logic [19:0] Bcd_c;
  logic [4:0]  Blank_c;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  signed_bcd_converter #(.HOLD_RESULT(1)) dut (
    .Clock(Clock), .Reset(Reset), .Value(Value), .Load(Load),
    .Busy(Busy), .Valid(Valid), .Negative(Negative), .Bcd(Bcd), .Blank(Blank)
  );

  signed_bcd_converter #(.HOLD_RESULT(0)) dut_clr (
    .Clock(Clock), .Reset(Reset), .Value(Value), .Load(Load),
    .Busy(Busy_c), .Valid(Valid_c), .Negative(Negative_c), .Bcd(Bcd_c), .Blank(Blank_c)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse Load for one edge, then count negedges with Busy high (bounded).
  task automatic run_conv(input logic [15:0] v, output int busy_cycles);
    @(negedge Clock);
    Value = v;
    Load  = 1'b1;
    @(negedge Clock);
    Load  = 1'b0;
    busy_cycles = 0;
    while (Busy && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge Clock);
    end
  endtask

  initial begin
    Reset = 1'b0;
    Load  = 1'b0;
    Value = 16'h0000;
    repeat (2) @(negedge Clock);
    check("rst_busy",  Busy,     1'b0);
    check("rst_valid", Valid,    1'b0);
    check("rst_neg",   Negative, 1'b0);
    check("rst_bcd",   Bcd,      20'h00000);
    check("rst_blank", Blank,    5'b11110);
    Reset = 1'b1;

    // Zero
    run_conv(16'h0000, cyc);
    check("zero_cyc",   cyc,      16);
    check("zero_valid", Valid,    1'b1);
    check("zero_bcd",   Bcd,      20'h00000);
    check("zero_neg",   Negative, 1'b0);
    check("zero_blank", Blank,    5'b11110);

    // Positive 12345
    run_conv(16'h3039, cyc);
    check("pos_cyc",   cyc,      16);
    check("pos_valid", Valid,    1'b1);
    check("pos_bcd",   Bcd,      20'h12345);
    check("pos_neg",   Negative, 1'b0);
    check("pos_blank", Blank,    5'b00000);

    // Negative -123
    run_conv(16'hFF85, cyc);
    check("neg_cyc",     cyc,        16);
    check("neg_bcd",     Bcd,        20'h00123);
    check("neg_neg",     Negative,   1'b1);
    check("neg_blank",   Blank,      5'b11000);
    check("neg_bcd_c",   Bcd_c,      20'h00123);
    check("neg_blank_c", Blank_c,    5'b11000);
    check("neg_neg_c",   Negative_c, 1'b1);

    // Most negative operand
    run_conv(16'h8000, cyc);
    check("min_bcd",   Bcd,      20'h32768);
    check("min_neg",   Negative, 1'b1);
    check("min_blank", Blank,    5'b00000);

    // Load while busy is ignored; hold vs clear behaviour during conversion
    @(negedge Clock);
    Value = 16'h0007;
    Load  = 1'b1;
    @(negedge Clock);                 // after accept edge k
    Load  = 1'b0;
    check("hold_busy",    Busy,       1'b1);
    check("hold_valid",   Valid,      1'b0);
    check("hold_bcd",     Bcd,        20'h32768);
    check("hold_neg",     Negative,   1'b1);
    check("clr_bcd",      Bcd_c,      20'h00000);
    check("clr_neg",      Negative_c, 1'b0);
    check("clr_blank",    Blank_c,    5'b11110);
    repeat (3) @(negedge Clock);      // after k+3
    Value = 16'h0009;
    Load  = 1'b1;
    @(negedge Clock);                 // after k+4
    Load  = 1'b0;
    Value = 16'h0000;
    repeat (11) @(negedge Clock);     // after k+15
    check("bl_valid_pre", Valid, 1'b0);
    check("bl_busy_pre",  Busy,  1'b1);
    @(negedge Clock);                 // after k+16
    check("bl_valid", Valid, 1'b1);
    check("bl_busy",  Busy,  1'b0);
    check("bl_bcd",   Bcd,   20'h00007);
    check("bl_blank", Blank, 5'b11110);

    // Back-to-back: Load on the completion edge ignored, one cycle later accepted
    @(negedge Clock);
    Value = 16'h0005;
    Load  = 1'b1;
    @(negedge Clock);                 // after k
    Load  = 1'b0;
    repeat (15) @(negedge Clock);     // after k+15
    check("b2b_valid_pre", Valid, 1'b0);
    Value = 16'h0099;
    Load  = 1'b1;
    @(negedge Clock);                 // after k+16
    check("b2b_valid", Valid, 1'b1);
    check("b2b_busy",  Busy,  1'b0);
    check("b2b_bcd",   Bcd,   20'h00005);
    Value = 16'h002A;
    @(negedge Clock);                 // after k+17, second load accepted
    Load  = 1'b0;
    check("b2b2_valid", Valid, 1'b0);
    check("b2b2_busy",  Busy,  1'b1);
    check("b2b2_bcd",   Bcd,   20'h00005);
    repeat (15) @(negedge Clock);
    check("b2b2_valid_pre", Valid, 1'b0);
    @(negedge Clock);
    check("b2b2_valid_end", Valid, 1'b1);
    check("b2b2_bcd_end",   Bcd,   20'h00042);
    check("b2b2_blank_end", Blank, 5'b11100);
    repeat (3) @(negedge Clock);
    check("done_hold_valid", Valid, 1'b1);
    check("done_hold_bcd",   Bcd,   20'h00042);

    // Reset in the middle of a conversion
    @(negedge Clock);
    Value = 16'h1234;
    Load  = 1'b1;
    @(negedge Clock);
    Load  = 1'b0;
    repeat (8) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("mid_busy",  Busy,     1'b0);
    check("mid_valid", Valid,    1'b0);
    check("mid_neg",   Negative, 1'b0);
    check("mid_bcd",   Bcd,      20'h00000);
    check("mid_blank", Blank,    5'b11110);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    check("post_rst_valid", Valid, 1'b0);
    run_conv(16'h1234, cyc);
    check("after_cyc",   cyc,   16);
    check("after_bcd",   Bcd,   20'h04660);
    check("after_blank", Blank, 5'b10000);
    check("after_neg",   Negative, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signed_bcd_converter.md
SIGNED_BCD_CONVERTER -- requirements
Module: signed_bcd_converter

Interface
REQ-001 Parameter: HOLD_RESULT, default 1, meaning: 1 = Bcd/Negative/Blank hold the previous result during a conversion; 0 = they clear to reset values when a Load is accepted.
REQ-002 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Value  input  16  two's-complement operand (the 16-bit signed multiplier Product); sampled only when a Load is accepted.
REQ-005 Load  input  1  start request; a one-cycle pulse, normally driven by the multiplier's Done.
REQ-006 Busy  output  1  high while a conversion is in progress.
REQ-007 Valid  output  1  high while Bcd/Negative/Blank hold a completed result.
REQ-008 Negative  output  1  sign of the converted Value.
REQ-009 Bcd  output  20  five BCD digits of |Value|; [19:16] is ten-thousands, [3:0] is units.
REQ-010 Blank  output  5  bit i = 1 means digit i is a leading zero; bit 0 is always 0.

Function
REQ-011 FSM states SHALL be IDLE, CONVERT and DONE.
REQ-012 FSM transitions SHALL be:
- IDLE --Load--> CONVERT
- DONE --Load--> CONVERT
- CONVERT --16th iteration--> DONE
- all other cases: hold state.
REQ-013 Load accepted (IDLE or DONE) SHALL, on that edge:
- latch Negative_int = Value[15];
- load a 17-bit magnitude with |Value|, so 16'h8000 gives 32768;
- clear the BCD shift register and the 4-bit iteration counter;
- set Busy = 1 and Valid = 0.
REQ-014 Load while in CONVERT SHALL be ignored with no effect on the conversion in progress.
REQ-015 Each CONVERT cycle SHALL perform one double-dabble iteration:
- first, add 3 to every working BCD digit whose value is 5 or greater;
- then, shift {BCD, magnitude} left by one bit.
REQ-016 Iteration count: exactly 16 iterations; the counter increments once per CONVERT cycle and terminates at 15.
REQ-017 On the 16th iteration edge the block SHALL, simultaneously:
- register Bcd, Negative and Blank;
- set Valid = 1 and Busy = 0;
- enter DONE.
REQ-018 Latency: with Load sampled at edge k, Valid SHALL be observed high after edge k+16.
REQ-019 Valid and outputs SHALL hold in DONE indefinitely until the next accepted Load or reset.
REQ-020 Blank SHALL be computed from the final digits: bit i (i = 4..1) = 1 iff digits i..4 are all zero.
REQ-021 Negative SHALL be 0 when Value = 0, i.e. there is no negative zero.
REQ-022 HOLD_RESULT = 0 SHALL clear Bcd, Negative and Blank to their reset values on the Load-accept edge; HOLD_RESULT = 1 SHALL leave them unchanged until completion.
REQ-023 Output type: all outputs SHALL be registered, with no combinational path from Value or Load to any output.
REQ-024 Working-digit width: no working BCD digit SHALL exceed 9 after any iteration for any 17-bit magnitude no greater than 32768.

Reset
REQ-025 Reset = 0 SHALL, asynchronously, force:
- state to IDLE;
- Busy = 0, Valid = 0, Negative = 0;
- Bcd = 20'h00000, Blank = 5'b11110;
- the counter and all working registers to 0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no partial result visible.
REQ-027 After reset release, the first Load SHALL behave exactly as a Load from IDLE.

Verification
REQ-028 Zero: Load with Value = 16'h0000 -> 16 cycles later Valid = 1, Bcd = 20'h00000, Negative = 0, Blank = 5'b11110.
REQ-029 Positive: Value = 16'h3039 -> Bcd = 20'h12345, Negative = 0, Blank = 5'b00000, Busy high for exactly 16 cycles.
REQ-030 Negative: Value = 16'hFF85 -> Bcd = 20'h00123, Negative = 1, Blank = 5'b11000; then Value = 16'h8000 -> Bcd = 20'h32768, Negative = 1.
REQ-031 Busy Load:
- stimulus: Load with 16'h0007, then a second Load with 16'h0009 four cycles later;
- response: result is Bcd = 20'h00007, and the second Load is ignored.
REQ-032 Back-to-back: Load in the same cycle Valid rises is not accepted (state is CONVERT); a Load one cycle later is accepted, Valid drops, and the new result appears 16 cycles later.
REQ-033 Reset mid-op: Reset low at iteration 8 of 16'h1234 -> all outputs at reset values immediately; after release, Load 16'h1234 gives Bcd = 20'h04660, Blank = 5'b10000.
